// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit, 8-operation ALU with a single registered output stage.
// Operands and opcode are sampled on the rising clock edge; Y and Cout
// are valid from just after that edge and hold until the next one.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] sel,
    output logic [7:0] Y,
    output logic       Cout
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [8:0] sum_w;
    logic [8:0] diff_w;
    logic [7:0] y_d;
    logic [7:0] y_q;
    logic       cout_d;
    logic       cout_q;

    // Adder and subtractor; subtraction is A + ~B + 1 so bit 8 is the no-borrow flag.
    always_comb begin
        sum_w  = {1'b0, A} + {1'b0, B};
        diff_w = {1'b0, A} + {1'b0, ~B} + 9'd1;
    end

    // Opcode decode selecting the next result and flag.
    always_comb begin
        y_d    = 8'h00;
        cout_d = 1'b0;
        case (sel)
            OP_ADD: begin
                y_d    = sum_w[7:0];
                cout_d = sum_w[8];
            end
            OP_SUB: begin
                y_d    = diff_w[7:0];
                cout_d = diff_w[8];
            end
            OP_AND: y_d = A & B;
            OP_OR:  y_d = A | B;
            OP_XOR: y_d = A ^ B;
            OP_NOT: y_d = ~A;
            OP_SHL: begin
                y_d    = {A[6:0], 1'b0};
                cout_d = A[7];
            end
            OP_SHR: begin
                y_d    = {1'b0, A[7:1]};
                cout_d = A[0];
            end
            default: begin
                y_d    = 8'h00;
                cout_d = 1'b0;
            end
        endcase
    end

    // Output register; reset wins over whatever operation is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= 8'h00;
            cout_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            cout_q <= cout_d;
        end
    end

    assign Y    = y_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed plan vectors plus random
// stimulus compared against an arithmetic reference model.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] sel;
    logic [7:0] Y;
    logic       Cout;

    int total = 0;
    int bad   = 0;

    alu_8bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .sel  (sel),
        .Y    (Y),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns Cout*256 + Y, computed with plain integer arithmetic.
    function automatic int ref_alu(input int a, input int b, input int s);
        int y;
        int c;
        y = 0;
        c = 0;
        case (s)
            0: begin y = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
            1: begin y = (a - b + 256) % 256; c = (a >= b) ? 1 : 0;      end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = 255 - a;
            6: begin y = (a * 2) % 256;       c = a / 128;               end
            7: begin y = a / 2;               c = a % 2;                 end
            default: y = 0;
        endcase
        return c * 256 + y;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one operation at the falling edge, then check just after the rising edge.
    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input string tag);
        int e;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        sel = s;
        @(posedge clk);
        #1;
        e = r ? 0 : ref_alu(int'(a), int'(b), int'(s));
        check({tag, "_y"}, int'(Y), e % 256);
        check({tag, "_c"}, int'(Cout), e / 256);
    endtask

    // Directed check against literal plan values, independent of the model.
    task automatic apply_lit(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                             input logic [7:0] ey, input logic ec, input string tag);
        @(negedge clk);
        rst = 1'b0;
        A   = a;
        B   = b;
        sel = s;
        @(posedge clk);
        #1;
        check({tag, "_y"}, int'(Y), int'(ey));
        check({tag, "_c"}, int'(Cout), int'(ec));
    endtask

    logic [7:0] sweep_y [8] = '{8'h76, 8'hDE, 8'h88, 8'hEE, 8'h66, 8'h55, 8'h54, 8'h55};
    logic       sweep_c [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        A   = 8'h00;
        B   = 8'h00;
        sel = 3'b000;

        // Reset held for two edges with live operands, then release.
        apply(1'b1, 8'hAA, 8'hCC, 3'd0, "rst0");
        apply(1'b1, 8'hAA, 8'hCC, 3'd0, "rst1");
        apply_lit(8'hAA, 8'hCC, 3'd0, 8'h76, 1'b1, "rst_rel");

        // Opcode sweep.
        for (int i = 0; i < 8; i++)
            apply_lit(8'hAA, 8'hCC, 3'(i), sweep_y[i], sweep_c[i], $sformatf("sweep%0d", i));

        // Arithmetic and shift boundaries.
        apply_lit(8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, "add_wrap");
        apply_lit(8'h00, 8'h00, 3'd0, 8'h00, 1'b0, "add_zero");
        apply_lit(8'h55, 8'h55, 3'd1, 8'h00, 1'b1, "sub_eq");
        apply_lit(8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, "sub_borrow");
        apply_lit(8'h80, 8'h00, 3'd6, 8'h00, 1'b1, "shl_msb");
        apply_lit(8'h01, 8'h00, 3'd7, 8'h00, 1'b1, "shr_lsb");
        apply_lit(8'hFE, 8'h00, 3'd7, 8'h7F, 1'b0, "shr_fe");

        // Hold: inputs change between edges, outputs must not.
        apply_lit(8'h12, 8'h34, 3'd0, 8'h46, 1'b0, "hold_pre");
        #2;
        A   = 8'hF0;
        B   = 8'hF0;
        sel = 3'd0;
        #1;
        check("hold_y", int'(Y), 32'h46);
        check("hold_c", int'(Cout), 0);

        // Mid-stream reset among back-to-back ADDs.
        apply_lit(8'h10, 8'h20, 3'd0, 8'h30, 1'b0, "mid_a");
        apply(1'b1, 8'hF0, 8'h20, 3'd0, "mid_rst");
        apply_lit(8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, "mid_b");

        // Random stimulus with occasional reset.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 19) == 0), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
